// File: rtl/arith_pkg.sv
// Shared arithmetic package for the ALU adder/subtractor pair.
// Holds the subtractor FSM state type and the default datapath geometry.
package arith_pkg;

    // Subtractor control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Default operand width and bits handled per cycle
    localparam int ARITH_WIDTH = 32;
    localparam int ARITH_CHUNK = 8;

    // Number of RUN cycles needed to cover a full operand
    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/sub_slice.sv
// One CHUNK-wide slice of the subtractor: diff = a + ~b + cin, with carry out.
// A carry out of 1 means "no borrow" from this slice.
module sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] diff_o,
    output logic         cout_o
);

    // Single short carry chain of W bits
    assign {cout_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor: RSub = DataA - DataB, CHUNK bits per
// clock, with the carry (inverted borrow) chained across cycles.
// Optional macro SUB_OVERFLOW_EN adds the signed Overflow output.
//
// Handshake: Start is sampled only in IDLE; the operands are captured on that
// same edge. Busy is high in RUN and DONE; Done pulses for exactly one cycle,
// and RSub/BorrowOut/Overflow are valid from that cycle until the next Done.
// Start while Busy is ignored (no queuing). rst wins over Start.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH,
    parameter int CHUNK = ARITH_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] RSub,
    output logic             BorrowOut,
`ifdef SUB_OVERFLOW_EN
    output logic             Overflow,
`endif
    output sub_state_t       dbg_state_o
);

    localparam int N     = chunk_count(WIDTH, CHUNK);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Refuse to build a geometry that cannot be tiled by whole slices
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("serial_subtractor: WIDTH must be a multiple of CHUNK");
    end

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] rsub_q, rsub_d;
    logic             borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_diff;
    logic             slice_cout;

    // Current chunk of each operand, selected by the chunk counter
    assign slice_a = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign slice_b = b_q[int'(cnt_q)*CHUNK +: CHUNK];

    sub_slice #(
        .W (CHUNK)
    ) u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .diff_o (slice_diff),
        .cout_o (slice_cout)
    );

    // Next-state logic: capture in IDLE, one chunk per RUN cycle, publish on DONE entry
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        shadow_d = shadow_q;
        rsub_d   = rsub_q;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = DataA;
                    b_d     = DataB;
                    carry_d = 1'b1;   // the "+1" of A + ~B + 1
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                shadow_d[int'(cnt_q)*CHUNK +: CHUNK] = slice_diff;
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    // Full result only becomes visible here, never partially
                    state_d  = DONE;
                    rsub_d   = shadow_d;
                    borrow_d = ~slice_cout;
`ifdef SUB_OVERFLOW_EN
                    ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                               (shadow_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; rst discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            shadow_q <= '0;
            rsub_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            shadow_q <= shadow_d;
            rsub_q   <= rsub_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign Busy        = (state_q == RUN) || (state_q == DONE);
    assign Done        = (state_q == DONE);
    assign RSub        = rsub_q;
    assign BorrowOut   = borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign Overflow    = ovf_q;
`endif
    assign dbg_state_o = state_q;

endmodule
